piso_serial_tx: RTL

- Parallel-in/serial-out transmitter for the KGP_miniRISC datapath: accepts a WIDTH-bit word over a valid/ready handshake and drives it out one bit per clock.
- Framing strobes mark the first and last bit; an even-parity bit and a done pulse close each frame.
- Transmit-side counterpart of the serial-in dff/shift-register capture chain: bits leave on `sout`, qualified by `sout_valid`, for a downstream flop chain to sample.

---
 rtl/piso_serial_tx.sv | 127 ++++++++++++
 1 files changed

// File: rtl/piso_serial_tx.sv
// Parallel-in/serial-out transmitter: takes a word over valid/ready and shifts it out
// one bit per clock with first/last strobes, even parity and a closing done pulse.
module piso_serial_tx #(
    parameter int WIDTH     = 32,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] din,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             first,
    output logic             last,
    output logic             parity,
    output logic             done,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic             load_ready_n, sout_n, sout_valid_n, first_n, last_n;
    logic             parity_n, done_n, busy_n;

    // The shift register always presents the next bit to send at its "head" end.
    function automatic logic head(input logic [WIDTH-1:0] w);
        return LSB_FIRST ? w[0] : w[WIDTH-1];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return LSB_FIRST ? (w >> 1) : (w << 1);
    endfunction

    always_comb begin
        state_n      = state;
        shreg_n      = shreg;
        cnt_n        = cnt;
        load_ready_n = load_ready;
        sout_n       = sout;
        sout_valid_n = sout_valid;
        first_n      = first;
        last_n       = last;
        parity_n     = parity;
        done_n       = done;
        busy_n       = busy;

        case (state)
            IDLE: begin
                load_ready_n = 1'b1;
                if (load_valid && load_ready) begin
                    state_n      = SHIFT;
                    shreg_n      = advance(din);
                    cnt_n        = '0;
                    load_ready_n = 1'b0;
                    busy_n       = 1'b1;
                    sout_n       = head(din);
                    sout_valid_n = 1'b1;
                    first_n      = 1'b1;
                    last_n       = 1'b0;
                    parity_n     = ^din;
                    done_n       = 1'b0;
                end
            end
            SHIFT: begin
                load_ready_n = 1'b0;
                busy_n       = 1'b1;
                first_n      = 1'b0;
                if (cnt == LAST_IDX) begin
                    state_n      = DONE;
                    sout_n       = 1'b0;
                    sout_valid_n = 1'b0;
                    last_n       = 1'b0;
                    done_n       = 1'b1;
                end else begin
                    cnt_n        = cnt + 1'b1;
                    sout_n       = head(shreg);
                    shreg_n      = advance(shreg);
                    sout_valid_n = 1'b1;
                    last_n       = ((cnt + 1'b1) == LAST_IDX);
                end
            end
            DONE: begin
                state_n      = IDLE;
                done_n       = 1'b0;
                busy_n       = 1'b0;
                load_ready_n = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            shreg      <= '0;
            cnt        <= '0;
            load_ready <= 1'b0;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            first      <= 1'b0;
            last       <= 1'b0;
            parity     <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            shreg      <= shreg_n;
            cnt        <= cnt_n;
            load_ready <= load_ready_n;
            sout       <= sout_n;
            sout_valid <= sout_valid_n;
            first      <= first_n;
            last       <= last_n;
            parity     <= parity_n;
            done       <= done_n;
            busy       <= busy_n;
        end
    end

endmodule
